// File: rtl/multicycle_alu_pkg.sv
// Shared ALU encoding: operation codes used by both the ALU controller and
// the multi-cycle execution unit, plus the default datapath width.
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SRA = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_SLT = 4'b1100
    } alu_op_e;

    // Shifts are the only operations that take the serial path.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Operand/result handshake bundle between the execute-stage front end
// (master) and the multi-cycle ALU (slave).
interface multicycle_alu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_op;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_zero;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero
    );
endinterface

// File: rtl/multicycle_alu_shift.sv
// Serial shifter: one bit per cycle. Holds the working register, the
// remaining-bit down-counter and the direction / arithmetic-fill mode.
module alu_shift_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   left_i,
    input  logic                   arith_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [SHAMT_WIDTH-1:0] amt_i,
    output logic                   busy_o,
    output logic                   last_o,
    output logic [DATA_WIDTH-1:0]  next_o
);

    logic [DATA_WIDTH-1:0]  work_q, work_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   left_q, left_d;
    logic                   arith_q, arith_d;

    // One-step shift of the working register; the right-shift fill repeats
    // the current MSB, which is always the original MSB of A.
    assign next_o = left_q ? {work_q[DATA_WIDTH-2:0], 1'b0}
                           : {arith_q & work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
    assign busy_o = (cnt_q != '0);
    assign last_o = (cnt_q == SHAMT_WIDTH'(1));

    // Next state: load a new job, or consume one bit while counting down.
    always_comb begin
        work_d  = work_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (load_i) begin
            work_d  = a_i;
            cnt_d   = amt_i;
            left_d  = left_i;
            arith_d = arith_i;
        end else if (busy_o) begin
            work_d = next_o;
            cnt_d  = cnt_q - SHAMT_WIDTH'(1);
        end
    end

    // Counter is control state and is cleared by reset, which drops any job.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Working data and mode are only meaningful while the counter is non-zero.
    always_ff @(posedge clk) begin
        work_q  <= work_d;
        left_q  <= left_d;
        arith_q <= arith_d;
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch operations and
// serial shifts, behind a valid/ready handshake on each side.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    multicycle_alu_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   in_ready_q;
    logic                   out_valid_q;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   start_shift;
    logic                   sh_busy;
    logic                   sh_last;
    logic [DATA_WIDTH-1:0]  sh_next;

    // Single-cycle result; shift codes only reach here with a zero amount.
    function automatic logic [DATA_WIDTH-1:0] alu_compute(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        case (alu_op_e'(op))
            OP_AND:                 return a & b;
            OP_OR:                  return a | b;
            OP_ADD:                 return a + b;
            OP_SUB:                 return a - b;
            OP_SLL, OP_SRL, OP_SRA: return a;
            OP_SLT:                 return {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_BEQ:                 return {{(DATA_WIDTH-1){1'b0}}, a == b};
            OP_BNE:                 return {{(DATA_WIDTH-1){1'b0}}, a != b};
            default:                return '0;
        endcase
    endfunction

    assign shamt       = bus.in_b[SHAMT_WIDTH-1:0];
    assign start_shift = (state_q == S_IDLE) && bus.in_valid &&
                         is_shift_op(bus.in_op) && (shamt != '0);

    alu_shift_unit #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (start_shift),
        .left_i  (bus.in_op == OP_SLL),
        .arith_i (bus.in_op == OP_SRA),
        .a_i     (bus.in_a),
        .amt_i   (shamt),
        .busy_o  (sh_busy),
        .last_o  (sh_last),
        .next_o  (sh_next)
    );

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (start_shift) begin
                            state_q <= S_SHIFT;
                        end else begin
                            result_q    <= alu_compute(bus.in_op, bus.in_a, bus.in_b);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    if (sh_busy && sh_last) begin
                        result_q    <= sh_next;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_zero   = (result_q == '0);

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Execution unit at the consuming end of the 4-bit `Operation` code produced by the ALU controller. It accepts operands plus an operation code through a valid/ready handshake and computes a 32-bit result. Logic, arithmetic, compare and branch operations complete in one cycle; shifts are done serially, one bit per cycle, to save area. It sits in the execute stage between the register-read/immediate mux and the writeback/branch logic, and stalls the pipeline through `in_ready`.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must be a power of two ≥ 8
- `SHAMT_WIDTH`, $clog2(DATA_WIDTH), shift-amount width taken from `in_b`
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  operands and operation present
- `in_ready`  output  1  unit can accept a new operation
- `in_op`  input  4  operation code (see Operation)
- `in_a`  input  DATA_WIDTH  operand A (rs1)
- `in_b`  input  DATA_WIDTH  operand B (rs2 or immediate)
- `out_valid`  output  1  result available
- `out_ready`  input  1  consumer accepts result
- `out_result`  output  DATA_WIDTH  result
- `out_zero`  output  1  high when `out_result` == 0

One clock; reset is synchronous and active-high.

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0111 SRA, 1100 SLT (signed), 1000 BEQ, 1001 BNE. Any other code: result 0.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- SLT: result 1 if signed A < signed B, else 0.
- BEQ: result 1 if A == B else 0; BNE: result 1 if A != B else 0.
- Shifts: shift amount = `in_b[SHAMT_WIDTH-1:0]`; upper bits of B ignored. SRA fills with A's original MSB.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `in_ready`=1. On `in_valid`: non-shift op or shift amount 0 → compute, register result, go DONE. Shift op with amount k>0 → load A into working register, load counter with k, go SHIFT.
  - SHIFT: each cycle shift working register one bit in the selected direction, decrement counter; when counter reaches 1 and the last bit is shifted, go DONE.
  - DONE: `out_valid`=1, result held stable. On `out_ready` → IDLE.
- `in_ready`=1 only in IDLE; no new op accepted in SHIFT or DONE, even if `out_ready` is high in DONE.
- Operands and op are captured at acceptance; later changes on inputs have no effect.
- `out_zero` is derived combinationally from the registered `out_result`.

## Timing
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, `out_zero`=1, counter 0.
- Non-shift op accepted at edge N: `out_valid` high from cycle N+1.
- Shift by k accepted at edge N: `out_valid` high from cycle N+1+k (k=0 behaves as non-shift). Maximum latency DATA_WIDTH cycles (k = DATA_WIDTH−1).
- Result handshake completes on the edge where `out_valid` and `out_ready` are both high. Earliest next acceptance is the following cycle, giving a 2-cycle minimum initiation interval.
- `out_valid` and `out_result` must not change while `out_valid`=1 and `out_ready`=0.
- Reset asserted in any state, including mid-shift: the next edge returns to the reset values and the in-flight operation is discarded.

## Structure
- Shared package `alu_pkg`: `alu_op_e` enum holding the ten op codes, shared with the ALU controller so that both ends use one encoding. Also holds the `DATA_WIDTH` default.
- FSM state enum is local to the module.
- Sub-module `alu_shift_unit`: working register, down-counter and direction/arith-fill control. Interface is load/start, `busy`, `result`. The top level owns the FSM, the single-cycle datapath and the output register.

## Test plan
- Reset, then ADD A=0x0000_0005, B=0xFFFF_FFFB → `out_valid` at N+1, result 0x0000_0000, `out_zero`=1.
- SUB A=3, B=5 → 0xFFFF_FFFE. SLT A=0xFFFF_FFFF, B=1 → 1. OR 0xF0 | 0x0F → 0xFF.
- SRA A=0x8000_0000, B=0x0000_0024 (amount 4) → `out_valid` at N+5, result 0xF800_0000. `in_ready`=0 for cycles N+1..N+5.
- SLL by 0 and SRL by 31 of 0x8000_0000 → latency 1 with result 0x8000_0000, and latency 32 with result 0x0000_0001.
- BNE A=B=0x1234 → result 0, `out_zero`=1. Hold `out_ready`=0 for 3 cycles → result stable and no new accept even with `in_valid`=1.
- Assert `reset` mid-SLL by 20 at cycle N+7 → next cycle IDLE, `out_valid`=0, `out_result`=0. A following ADD completes normally.
